// File: rtl/cordic_seg_find.sv
// Vector-to-segment finder: walks the CORDIC seed ROM and returns the largest seed angle <= vector angle.
// Optional first-octant input folding is built when CORDIC_SEG_FOLD_EN is defined.
module cordic_seg_find #(
  parameter int W    = 22,
  parameter int NSEG = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic [3:0]          rom_addr,
  input  logic signed [W-1:0] rom_x,
  input  logic signed [W-1:0] rom_y,
  output logic                busy,
  output logic                done,
  output logic [3:0]          seg_idx,
  output logic                below,
  output logic                err,
  output logic [2:0]          oct
);

  typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NSEG - 1);

  state_t              state_reg, state_next;
  logic signed [W-1:0] x_reg, y_reg;
  logic [3:0]          k_reg;
  logic [3:0]          seg_reg;
  logic                below_reg, err_reg;
  logic [2:0]          oct_reg;

  logic signed [W-1:0] cap_x, cap_y;
  logic [2:0]          cap_oct;
  logic                cap_err;

`ifdef CORDIC_SEG_FOLD_EN
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

  logic signed [W-1:0] ax, ay;
  logic                swap;

  // Saturate |-2^(W-1)| so the folded magnitude stays representable.
  assign ax   = (x_in == SMIN) ? SMAX : (x_in < 0) ? -x_in : x_in;
  assign ay   = (y_in == SMIN) ? SMAX : (y_in < 0) ? -y_in : y_in;
  assign swap = (ay > ax);

  assign cap_x   = swap ? ay : ax;
  assign cap_y   = swap ? ax : ay;
  assign cap_oct = {x_in < 0, y_in < 0, swap};
  assign cap_err = (x_in == '0) && (y_in == '0);
`else
  assign cap_x   = x_in;
  assign cap_y   = y_in;
  assign cap_oct = 3'd0;
  // y >= 0 together with y <= x also forces x >= 0.
  assign cap_err = ((x_in == '0) && (y_in == '0)) || (y_in < 0) || (y_in > x_in);
`endif

  // Cross product sign: d >= 0 means the vector angle is at or above seed k.
  logic signed [2*W-1:0] p_yx, p_xy;
  logic signed [2*W:0]   d;
  logic                  ge;

  assign p_yx = y_reg * rom_x;
  assign p_xy = x_reg * rom_y;
  assign d    = {p_yx[2*W-1], p_yx} - {p_xy[2*W-1], p_xy};
  assign ge   = ~d[2*W];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = err_reg ? DONE : CMP;
      CMP:     state_next = (ge && (k_reg != LAST)) ? FETCH : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      k_reg     <= '0;
      seg_reg   <= '0;
      below_reg <= 1'b0;
      err_reg   <= 1'b0;
      oct_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg     <= cap_x;
            y_reg     <= cap_y;
            oct_reg   <= cap_oct;
            err_reg   <= cap_err;
            below_reg <= 1'b0;
            seg_reg   <= '0;
            k_reg     <= '0;
          end
        end
        CMP: begin
          if (ge) begin
            if (k_reg == LAST) seg_reg <= k_reg;
            else               k_reg   <= k_reg + 4'd1;
          end else if (k_reg == 4'd0) begin
            below_reg <= 1'b1;
            seg_reg   <= '0;
          end else begin
            seg_reg <= k_reg - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr = k_reg;
  assign busy     = (state_reg == FETCH) || (state_reg == CMP);
  assign done     = (state_reg == DONE);
  assign seg_idx  = seg_reg;
  assign below    = below_reg;
  assign err      = err_reg;
  assign oct      = oct_reg;

endmodule

// File: tb/tb_cordic_seg_find.sv
// Scoreboard bench for cordic_seg_find: directed vectors push expected results, a monitor checks each done.
// Expectations follow CORDIC_SEG_FOLD_EN when the bench is compiled with it.
module tb_cordic_seg_find;

  localparam int W = 22;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic signed [W-1:0] x_in = '0, y_in = '0;
  logic [3:0]          rom_addr;
  logic signed [W-1:0] rom_x = '0, rom_y = '0;
  logic                busy, done, below, err;
  logic [3:0]          seg_idx;
  logic [2:0]          oct;

  cordic_seg_find #(.W(W), .NSEG(13)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .rom_addr(rom_addr), .rom_x(rom_x), .rom_y(rom_y),
    .busy(busy), .done(done), .seg_idx(seg_idx), .below(below), .err(err), .oct(oct)
  );

  always #5 clk = ~clk;

  // Seed ROM model: angle_k = (k+0.5)*3.58 deg, unit = 2^20, one clock read latency.
  int tab_x[13];
  int tab_y[13];
  initial begin
    for (int k = 0; k < 13; k++) begin
      real a;
      a = (k + 0.5) * 3.58 * 3.14159265358979 / 180.0;
      tab_x[k] = $rtoi($cos(a) * 1048576.0 + 0.5);
      tab_y[k] = $rtoi($sin(a) * 1048576.0 + 0.5);
    end
  end

  always @(posedge clk) begin
    if (rom_addr < 4'd13) begin
      rom_x <= W'(tab_x[rom_addr]);
      rom_y <= W'(tab_y[rom_addr]);
    end else begin
      rom_x <= '0;
      rom_y <= '0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endfunction

  typedef struct {
    int seg; int bel; int er; int oc; int lat; int maxa; int e0; string name;
  } exp_t;

  exp_t exp_q[$];
  int   done_cnt = 0;
  int   max_addr = 0;

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      max_addr = 0;
    end else begin
      if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_seg"},     int'(seg_idx), e.seg);
          chk({e.name, "_below"},   int'(below),   e.bel);
          chk({e.name, "_err"},     int'(err),     e.er);
          chk({e.name, "_oct"},     int'(oct),     e.oc);
          chk({e.name, "_latency"}, cyc - e0_fix(e.e0), e.lat);
          chk({e.name, "_maxaddr"}, max_addr,      e.maxa);
          $display("txn %s: seg=%0d below=%0d err=%0d oct=%0d lat=%0d", e.name, seg_idx, below, err, oct, cyc - e.e0);
        end
        max_addr = 0;
      end
    end
  end

  function automatic int e0_fix(int v);
    return v;
  endfunction

  task automatic run(input string name, input int x, input int y, input int seg, input int bel,
                     input int er, input int oc, input int lat, input int maxa, input bit poke);
    exp_t e;
    int   d0;
    d0 = done_cnt;
    @(negedge clk);
    x_in  = W'(x);
    y_in  = W'(y);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = '{seg, bel, er, oc, lat, maxa, cyc, name};
    exp_q.push_back(e);
    chk({name, "_busy"}, int'(busy), 1);
    if (poke) begin
      repeat (5) @(negedge clk);
      x_in  = W'(1048576);
      y_in  = W'(0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) chk({name, "_done_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_seg", int'(seg_idx), 0);
    chk("reset_below", int'(below), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_oct", int'(oct), 0);
    chk("reset_addr", int'(rom_addr), 0);

    run("zero_deg",  1048576, 0,       0,  1, 0, 0, 2,  0,  1'b0);
    run("deg45",     1048576, 1048576, 12, 0, 0, 0, 26, 12, 1'b0);
    run("deg10",     1048576, 184884,  2,  0, 0, 0, 8,  3,  1'b0);
    run("seed5_eq",  tab_x[5], tab_y[5], 5, 0, 0, 0, 14, 6, 1'b0);
`ifdef CORDIC_SEG_FOLD_EN
    run("x100_y200", 100, 200,          6, 0, 0, 1, 16, 7, 1'b0);
    run("neg_quad",  -1048576, -184884, 2, 0, 0, 6, 8,  3, 1'b0);
`else
    run("x100_y200", 100, 200,          0, 0, 1, 0, 1,  0, 1'b0);
    run("neg_quad",  -1048576, -184884, 0, 0, 1, 0, 1,  0, 1'b0);
`endif
    run("zero_vec",  0, 0,              0, 0, 1, 0, 1,  0, 1'b0);
    run("poke_scan", 1048576, 1048576, 12, 0, 0, 0, 26, 12, 1'b1);

    // Abort a scan with reset in its fifth cycle; nothing may complete afterwards.
    d0 = done_cnt;
    @(negedge clk);
    x_in  = W'(1048576);
    y_in  = W'(1048576);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_seg", int'(seg_idx), 0);
    chk("abort_below", int'(below), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_addr", int'(rom_addr), 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    $display("txn abort: busy=%0d seg=%0d", busy, seg_idx);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cordic_seg_find.md
# cordic_seg_find

Vector-to-segment finder: the reading, inverse-direction counterpart of the CORDIC seed ROM. Given a vector (x_in, y_in), it walks the 13-entry cos/sin seed table through the ROM's registered read port. It returns the index of the largest seed angle not exceeding the vector's angle, where the seed angles are (k+0.5)·~3.58°, k=0..12, spanning 0–45°. It sits in front of the vectoring-mode CORDIC core and supplies that core's coarse starting segment.

## Interface
- W, 22: sample/seed width, two's complement.
- NSEG, 13: number of table entries; last valid address NSEG-1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in, y_in  in  W  signed input vector; captured on the accepted start edge.
- rom_addr  out  4  registered address to seed ROM.
- rom_x, rom_y  in  W  ROM cos/sin data; valid the cycle after rom_addr is presented; ROM latency is 1 clock.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse; result valid from this cycle until the next accept.
- seg_idx  out  4  result index, 0..12.
- below  out  1  input angle is below seed 0; seg_idx=0.
- err  out  1  input is outside the accepted domain, or is the zero vector.
- oct  out  3  octant code; 0 when the folding feature is compiled out.

## Operation
- States: IDLE, FETCH, CMP, DONE.
- IDLE + start:
  - Capture the vector, with folding if enabled.
  - Zero vector or domain error → DONE with err=1, seg_idx=0.
  - Otherwise k=0, rom_addr=0 → FETCH.
- FETCH: rom_addr=k is held; ROM samples it → CMP.
- CMP: compute d = y·rom_x − x·rom_y.
  - Products are 2W-bit signed; d is 2W+1 bits with no truncation.
  - ge = (d ≥ 0), meaning angle ≥ seed k; equality counts as ge.
  - ge and k<12 → k=k+1 → FETCH.
  - ge and k=12 → seg_idx=12 → DONE.
  - !ge and k=0 → seg_idx=0, below=1 → DONE.
  - !ge and k>0 → seg_idx=k−1 → DONE.
- DONE: done=1 for one cycle, busy=0 → IDLE. Results hold until the next accept, which clears below and err.
- Domain without folding: 0 ≤ y_in ≤ x_in. Anything else sets err=1.
- start while busy or in DONE is ignored; there is no queueing.

## Timing
- Reset values: state IDLE, rom_addr=0, busy=0, done=0, seg_idx=0, below=0, err=0, oct=0, k=0.
- Reset mid-operation returns to IDLE on that edge. No done is produced, and any previous result is cleared.
- A start sampled at edge E0 sets busy in the following cycle.
- With n compares (1..13), done is high in the cycle after edge E0+2n. Maximum latency is 26 cycles.
- Error or zero vector: done in the cycle after E0+1.
- Back-to-back: a start in the cycle done is high is ignored; the earliest new accept is the following cycle.

## Configuration
- CORDIC_SEG_FOLD_EN defined:
  - Inputs of any sign are folded to the first octant on capture: x=|x_in|, y=|y_in|, then swap if y>x.
  - |−2^(W−1)| saturates to 2^(W−1)−1.
  - oct = {x_in<0, y_in<0, swapped}.
  - err is raised only for the zero vector.
- Undefined:
  - No folding logic is built and oct is tied to 0.
  - Out-of-domain inputs give err=1, seg_idx=0, with done in the cycle after E0+1.

## Test plan
- x=1048576, y=0 → below=1, seg_idx=0, err=0; done in the cycle after E0+2; rom_addr shows only 0.
- x=1048576, y=1048576 (45°) → seg_idx=12, below=0; done in the cycle after E0+26; rom_addr steps 0..12.
- x=1048576, y=184884 (~10°) → seg_idx=2 after 4 compares; done in the cycle after E0+8.
- x=rom c5, y=rom s5 (exact seed 5, equality) → seg_idx=5 after 7 compares, done in the cycle after E0+14.
- Zero vector and out-of-domain input:
  - Fold off, x=100, y=200 → err=1, done in the cycle after E0+1.
  - Fold on, x=−1048576, y=−184884 → seg_idx=2, oct=3'b110.
  - Fold on, x=0, y=0 → err=1, done in the cycle after E0+1.
- Robustness:
  - Pulse start again mid-scan → ignored, original result is unchanged.
  - Assert rst at cycle 5 of a scan → next cycle all outputs are at reset values and no done pulse appears.
